// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the execute stage and the HI/LO multiply/divide unit.
// The master side issues operations; the slave side is the unit itself.
interface hilo_muldiv_if #(parameter int DATA_W = 32);
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] opa_i;
  logic [DATA_W-1:0] opb_i;
  logic              cancel_i;
  logic              ready_o;
  logic              alloc_o;
  logic              wb_o;
  logic              hilo_we_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, cancel_i,
    input  ready_o, alloc_o, wb_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, cancel_i,
    output ready_o, alloc_o, wb_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO, one bit per cycle.
// Every accepted op retires with exactly one wb_o pulse, even when aborted.
module hilo_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  hilo_muldiv_if.slave   bus
);
  localparam int CW = $clog2(DATA_W);
  localparam int AW = 2 * DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_DONE, S_ABORT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic              is_div;
  logic              neg_lo;   // product sign (mul) or quotient sign (div)
  logic              neg_hi;   // remainder sign (div only)
  logic [DATA_W-1:0] opb_q;
  logic [AW-1:0]     acc;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic              signed_op;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum;
  logic [AW-1:0]     mul_step;
  logic [DATA_W:0]   trial;
  logic [DATA_W+1:0] diff;
  logic [AW-1:0]     div_step;
  logic [AW-1:0]     prod_fix;
  logic [DATA_W-1:0] rem_fix, quo_fix;

  assign bus.ready_o   = (state == S_IDLE);
  assign bus.alloc_o   = bus.start_i & bus.ready_o & ~bus.cancel_i;
  assign bus.wb_o      = (state == S_DONE) || (state == S_ABORT);
  assign bus.hilo_we_o = (state == S_DONE);
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;

  // Operand magnitudes; the most negative value maps to itself as unsigned.
  assign signed_op = ~bus.op_i[0];
  assign a_mag = (signed_op && bus.opa_i[DATA_W-1]) ? -bus.opa_i : bus.opa_i;
  assign b_mag = (signed_op && bus.opb_i[DATA_W-1]) ? -bus.opb_i : bus.opb_i;

  // Shift-add: multiplier sits in acc low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc[AW-1:DATA_W]} + (acc[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
  assign mul_step = {mul_sum, acc[DATA_W-1:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}; no borrow means quotient bit 1.
  assign trial    = acc[AW-1:DATA_W-1];
  assign diff     = {1'b0, trial} - {2'b00, opb_q};
  assign div_step = diff[DATA_W+1] ? {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                   : {diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};

  assign prod_fix = neg_lo ? -acc : acc;
  assign rem_fix  = neg_hi ? -acc[AW-1:DATA_W]  : acc[AW-1:DATA_W];
  assign quo_fix  = neg_lo ? -acc[DATA_W-1:0]   : acc[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.alloc_o) state_nxt = S_CALC;
      S_CALC:  if (bus.cancel_i)     state_nxt = S_ABORT;
               else if (cnt == '0)   state_nxt = S_FIX;
      S_FIX:   state_nxt = bus.cancel_i ? S_ABORT : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      opb_q  <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.alloc_o) begin
          cnt    <= '1;
          is_div <= bus.op_i[1];
          neg_lo <= signed_op & (bus.opa_i[DATA_W-1] ^ bus.opb_i[DATA_W-1]);
          neg_hi <= signed_op & bus.opa_i[DATA_W-1];
          opb_q  <= b_mag;
          acc    <= {{DATA_W{1'b0}}, a_mag};
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          acc <= is_div ? div_step : mul_step;
        end
        // A cancel during FIX must leave HI/LO untouched.
        S_FIX: if (!bus.cancel_i) begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[AW-1:DATA_W];
            lo_q <= prod_fix[DATA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized + directed bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_alloc = 0;
  int   n_wb = 0;

  hilo_muldiv_if #(.DATA_W(32)) bus ();
  hilo_muldiv #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Tracker stand-in: allocate/retire pulse counts, cleared by the shared reset.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      n_alloc = 0;
      n_wb    = 0;
    end else begin
      if (bus.alloc_o) n_alloc++;
      if (bus.wb_o)    n_wb++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    logic [63:0]     res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    q = '0;
    r = '0;
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = 64'(ua * ub);
      2'b10: begin
        if (b == 32'd0) begin
          q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          r = a;
        end else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end
        res = {r, q};
      end
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = a;
        end else begin
          q = 32'(ua / ub);
          r = 32'(ua % ub);
        end
        res = {r, q};
      end
    endcase
    return res;
  endfunction

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!bus.ready_o && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.ready_o) chk({tag, "/ready_timeout"}, 64'(bus.ready_o), 64'd1);
  endtask

  // Issue one op and follow it to its retire; cancel_at = cycle offset of a flush (0 = none).
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int cancel_at);
    logic [63:0] exp, prev;
    int          wbk;
    logic        we;
    wait_ready(tag);
    prev = {bus.hi_o, bus.lo_o};
    exp  = model(op, a, b);
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.opa_i = a; bus.opb_i = b; bus.cancel_i = 1'b0;
    #1;
    chk({tag, "/alloc"}, 64'(bus.alloc_o), 64'd1);
    wbk = -1;
    we  = 1'b0;
    for (int k = 1; k <= 40 && wbk < 0; k++) begin
      @(negedge clk);
      bus.start_i  = 1'b0;
      bus.cancel_i = (k == cancel_at);
      bus.opa_i    = $urandom;
      bus.opb_i    = $urandom;
      #1;
      if (bus.wb_o) begin
        wbk = k;
        we  = bus.hilo_we_o;
      end
    end
    bus.cancel_i = 1'b0;
    chk({tag, "/wb_cycle"}, 64'(wbk), 64'((cancel_at > 0) ? cancel_at + 1 : 34));
    chk({tag, "/hilo_we"}, 64'(we), 64'((cancel_at > 0) ? 0 : 1));
    chk({tag, "/hilo"}, {bus.hi_o, bus.lo_o}, (cancel_at > 0) ? prev : exp);
    @(negedge clk);
    #1;
    chk({tag, "/ready_after"}, 64'(bus.ready_o), 64'd1);
    chk({tag, "/wb_single"}, 64'(bus.wb_o), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ap[3];
    int na;
    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.opa_i = '0; bus.opb_i = '0; bus.cancel_i = 1'b0;
    #1;
    chk("rst/ready", 64'(bus.ready_o), 64'd1);
    chk("rst/outs", {60'd0, bus.alloc_o, bus.wb_o, bus.hilo_we_o, 1'b0}, 64'd0);
    chk("rst/hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_neg/lit", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg/lit", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0, 0);
    chk("divu_zero/lit", {bus.hi_o, bus.lo_o}, 64'h0000_0064_FFFF_FFFF);
    do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf/lit", {bus.hi_o, bus.lo_o}, 64'h0000_0000_8000_0000);
    do_op("div_zero",  2'b10, 32'hFFFF_FFF0, 32'd0, 0);
    do_op("cancel10",  2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    chk("cancel10/balance", 64'(n_alloc - n_wb), 64'd0);
    do_op("cancel_fix", 2'b10, 32'd1000, 32'd7, 33);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      int ca;
      op = 2'($urandom_range(0, 3));
      ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 33)) : 0;
      do_op($sformatf("rnd%0d_op%0d", i, op), op, pick(), pick(), ca);
    end
    chk("rnd/balance", 64'(n_alloc - n_wb), 64'd0);

    // Idle + cancel must block issue.
    wait_ready("idle_cancel");
    @(negedge clk);
    bus.start_i = 1'b1; bus.cancel_i = 1'b1;
    #1;
    chk("idle_cancel/alloc", 64'(bus.alloc_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0; bus.cancel_i = 1'b0;
    #1;
    chk("idle_cancel/ready", 64'(bus.ready_o), 64'd1);

    // start_i held for 100 cycles: issues only when idle.
    ap = '{-1, -1, -1};
    na = 0;
    bus.op_i = 2'b01; bus.opa_i = 32'd3; bus.opb_i = 32'd4;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.start_i = 1'b1;
      #1;
      if (bus.alloc_o) begin
        if (na < 3) ap[na] = c;
        na++;
      end
    end
    bus.start_i = 1'b0;
    chk("hold/count", 64'(na), 64'd3);
    chk("hold/first", 64'(ap[0]), 64'd0);
    chk("hold/second", 64'(ap[1]), 64'd35);
    chk("hold/third", 64'(ap[2]), 64'd70);
    wait_ready("hold");
    @(negedge clk);
    chk("hold/balance", 64'(n_alloc - n_wb), 64'd0);

    // Asynchronous reset mid-operation: no retire, everything back to reset values.
    do_op("pre_reset", 2'b00, 32'h0001_2345, 32'hFFFF_0003, 0);
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b11; bus.opa_i = 32'd77; bus.opb_i = 32'd5;
    #1;
    chk("rst_mid/alloc", 64'(bus.alloc_o), 64'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid/ready", 64'(bus.ready_o), 64'd1);
    chk("rst_mid/outs", {61'd0, bus.alloc_o, bus.wb_o, bus.hilo_we_o}, 64'd0);
    chk("rst_mid/hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rst_mid/no_wb", 64'(bus.wb_o), 64'd0);
    end
    rst_n = 1'b1;
    do_op("post_reset", 2'b11, 32'hDEAD_BEEF, 32'd16, 0);
    @(negedge clk);
    chk("post_reset/balance", 64'(n_alloc - n_wb), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
